// File: rtl/seq_dtree_engine.sv
// Time-multiplexed decision-tree classifier: one node comparison per cycle over a
// loadable node table, walking from node 0 to a leaf under a depth guard.
module seq_dtree_engine #(
  parameter int unsigned N_FEATURES = 6,
  parameter int unsigned FEAT_W     = 8,
  parameter int unsigned CLASS_W    = 2,
  parameter int unsigned NODE_AW    = 5,
  parameter int unsigned FIDX_W     = 3,
  parameter int unsigned MAX_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_FEATURES*FEAT_W-1:0] in_feat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CLASS_W-1:0]           out_class,
  output logic                         out_err,
  output logic [NODE_AW:0]             out_steps,
  input  logic                         cfg_we,
  input  logic [NODE_AW-1:0]           cfg_addr,
  input  logic                         cfg_leaf,
  input  logic [FIDX_W-1:0]            cfg_feat,
  input  logic [FEAT_W-1:0]            cfg_thr,
  input  logic [NODE_AW-1:0]           cfg_left,
  input  logic [NODE_AW-1:0]           cfg_right,
  input  logic [CLASS_W-1:0]           cfg_class,
  output logic                         cfg_ack
);

  localparam int unsigned NumNodes = 2 ** NODE_AW;
  localparam int unsigned StepW    = NODE_AW + 1;
  localparam logic [StepW-1:0] MaxSteps = StepW'(MAX_DEPTH);

  typedef struct packed {
    logic                leaf;
    logic [FIDX_W-1:0]   fidx;
    logic [FEAT_W-1:0]   thr;
    logic [NODE_AW-1:0]  left;
    logic [NODE_AW-1:0]  right;
    logic [CLASS_W-1:0]  cls;
  } node_t;

  localparam node_t NodeRst = '{leaf: 1'b1, fidx: '0, thr: '0, left: '0, right: '0, cls: '0};

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  state_e                      state_q, state_d;
  logic [NODE_AW-1:0]          idx_q, idx_d;
  logic [StepW-1:0]            steps_q, steps_d;
  logic [N_FEATURES*FEAT_W-1:0] feat_q, feat_d;
  logic [CLASS_W-1:0]          class_q, class_d;
  logic                        err_q, err_d;
  logic [StepW-1:0]            osteps_q, osteps_d;
  logic                        cfg_ack_q;

  node_t       node_q [NumNodes];
  node_t       cur;
  logic [FEAT_W-1:0] sel_feat;
  logic        go_left;
  logic        cfg_apply;

  // Inference wins a same-cycle tie with a config write.
  assign cfg_apply = cfg_we && (state_q == StIdle) && !in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumNodes; i++) node_q[i] <= NodeRst;
      cfg_ack_q <= 1'b0;
    end else begin
      cfg_ack_q <= cfg_apply;
      if (cfg_apply) begin
        node_q[cfg_addr] <= '{leaf: cfg_leaf, fidx: cfg_feat, thr: cfg_thr, left: cfg_left,
                              right: cfg_right, cls: cfg_class};
      end
    end
  end

  assign cur = node_q[idx_q];

  // Out-of-range feature indices read as zero, so such a node always goes left.
  always_comb begin
    sel_feat = '0;
    for (int i = 0; i < N_FEATURES; i++) begin
      if (cur.fidx == FIDX_W'(i)) sel_feat = feat_q[i*FEAT_W +: FEAT_W];
    end
  end

  assign go_left = (sel_feat <= cur.thr);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    steps_d  = steps_q;
    feat_d   = feat_q;
    class_d  = class_q;
    err_d    = err_q;
    osteps_d = osteps_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          feat_d  = in_feat;
          idx_d   = '0;
          steps_d = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (cur.leaf) begin
          class_d  = cur.cls;
          err_d    = 1'b0;
          osteps_d = steps_q;
          state_d  = StDone;
        end else if (steps_q == MaxSteps) begin
          class_d  = '0;
          err_d    = 1'b1;
          osteps_d = steps_q;
          state_d  = StDone;
        end else begin
          idx_d   = go_left ? cur.left : cur.right;
          steps_d = steps_q + StepW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      steps_q  <= '0;
      feat_q   <= '0;
      class_q  <= '0;
      err_q    <= 1'b0;
      osteps_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      steps_q  <= steps_d;
      feat_q   <= feat_d;
      class_q  <= class_d;
      err_q    <= err_d;
      osteps_q <= osteps_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_class = class_q;
  assign out_err   = err_q;
  assign out_steps = osteps_q;
  assign cfg_ack   = cfg_ack_q;

endmodule

// File: tb/tb_seq_dtree_engine.sv
// Bench for seq_dtree_engine: directed scenarios plus random tables and vectors,
// checked against a table-walk reference model.
module tb_seq_dtree_engine;

  localparam int NF = 6;
  localparam int FW = 8;
  localparam int CW = 2;
  localparam int AW = 5;
  localparam int XW = 3;
  localparam int MD = 8;
  localparam int NN = 2 ** AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NF*FW-1:0]  in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_class;
  logic              out_err;
  logic [AW:0]       out_steps;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic              cfg_leaf;
  logic [XW-1:0]     cfg_feat;
  logic [FW-1:0]     cfg_thr;
  logic [AW-1:0]     cfg_left;
  logic [AW-1:0]     cfg_right;
  logic [CW-1:0]     cfg_class;
  logic              cfg_ack;

  int n_checks = 0;
  int n_errors = 0;

  // Reference node table.
  bit m_leaf  [NN];
  int m_fidx  [NN];
  int m_thr   [NN];
  int m_left  [NN];
  int m_right [NN];
  int m_class [NN];

  seq_dtree_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .out_steps (out_steps),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_leaf  (cfg_leaf),
    .cfg_feat  (cfg_feat),
    .cfg_thr   (cfg_thr),
    .cfg_left  (cfg_left),
    .cfg_right (cfg_right),
    .cfg_class (cfg_class),
    .cfg_ack   (cfg_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NN; i++) begin
      m_leaf[i] = 1'b1; m_fidx[i] = 0; m_thr[i] = 0;
      m_left[i] = 0; m_right[i] = 0; m_class[i] = 0;
    end
  endtask

  // Walk the reference table from the root following the classification rules.
  task automatic model_walk(input logic [NF*FW-1:0] v, output int c, output int e, output int s);
    int idx;
    int fv;
    idx = 0; c = 0; e = 0; s = 0;
    for (int g = 0; g < 100; g++) begin
      if (m_leaf[idx]) begin
        c = m_class[idx];
        break;
      end
      if (s == MD) begin
        e = 1;
        c = 0;
        break;
      end
      fv = (m_fidx[idx] < NF) ? int'(v[m_fidx[idx]*FW +: FW]) : 0;
      idx = (fv <= m_thr[idx]) ? m_left[idx] : m_right[idx];
      s++;
    end
  endtask

  // Called just after a rising edge with the engine idle.
  task automatic cfg_write(input int a, input bit lf, input int f, input int t, input int l,
                           input int r, input int c);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_leaf = lf; cfg_feat = XW'(f); cfg_thr = FW'(t);
    cfg_left = AW'(l); cfg_right = AW'(r); cfg_class = CW'(c);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_ack", cfg_ack, 1);
    m_leaf[a] = lf; m_fidx[a] = f; m_thr[a] = t;
    m_left[a] = l; m_right[a] = r; m_class[a] = c;
  endtask

  // Submit one vector, check latency and result, optionally backpressure for 'hold' cycles
  // while attempting a config write, and optionally collide a config write with the accept.
  task automatic run_vec(input logic [NF*FW-1:0] v, input int ec, input int ee, input int es,
                         input int hold, input bit tie);
    int cyc;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_feat  = v;
    if (tie) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_leaf = 1'b1; cfg_class = 2'd2;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (tie) check("tie_ack", cfg_ack, 0);
    check("in_ready_busy", in_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, es + 2);
    check("class", out_class, ec);
    check("err", out_err, ee);
    check("steps", out_steps, es);
    for (int k = 0; k < hold; k++) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_leaf = 1'b1; cfg_class = 2'd2;
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_class", out_class, ec);
      check("bp_err", out_err, ee);
      check("bp_steps", out_steps, es);
      check("bp_in_ready", in_ready, 0);
      check("bp_ack", cfg_ack, 0);
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [NF*FW-1:0] v;
    int ec, ee, es;
    bit saw;

    rst = 1'b1; in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_leaf = 1'b0; cfg_feat = '0; cfg_thr = '0;
    cfg_left = '0; cfg_right = '0; cfg_class = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_class", out_class, 0);
    check("rst_err", out_err, 0);
    check("rst_steps", out_steps, 0);
    check("rst_ack", cfg_ack, 0);
    rst = 1'b0;

    // Default table: root is a class-0 leaf.
    run_vec('0, 0, 0, 0, 0, 1'b0);

    // One split on X5 at threshold 31.
    cfg_write(0, 1'b0, 5, 31, 1, 2, 0);
    cfg_write(1, 1'b1, 0, 0, 0, 0, 1);
    cfg_write(2, 1'b1, 0, 0, 0, 0, 3);
    v = '0; v[5*FW +: FW] = 8'd31;
    run_vec(v, 1, 0, 1, 0, 1'b0);
    v[5*FW +: FW] = 8'd32;
    run_vec(v, 3, 0, 1, 0, 1'b0);

    // Backpressure with dropped config writes, then re-run on the unchanged table.
    v[5*FW +: FW] = 8'd31;
    run_vec(v, 1, 0, 1, 5, 1'b0);
    run_vec(v, 1, 0, 1, 0, 1'b0);

    // Config write colliding with an accepted vector is dropped.
    run_vec(v, 1, 0, 1, 0, 1'b1);
    run_vec(v, 1, 0, 1, 0, 1'b0);

    // Back-to-back writes to one address: the last one wins.
    cfg_write(1, 1'b1, 0, 0, 0, 0, 2);
    cfg_write(1, 1'b1, 0, 0, 0, 0, 3);
    run_vec(v, 3, 0, 1, 0, 1'b0);

    // Out-of-range feature index reads as zero and goes left.
    cfg_write(0, 1'b0, 6, 0, 1, 2, 0);
    run_vec({NF{8'hff}}, 3, 0, 1, 0, 1'b0);
    cfg_write(0, 1'b0, 7, 0, 2, 1, 0);
    run_vec({NF{8'hff}}, 3, 0, 1, 0, 1'b0);

    // Three-level chain of splits.
    cfg_write(0, 1'b0, 3, 127, 1, 4, 0);
    cfg_write(1, 1'b0, 4, 127, 3, 4, 0);
    cfg_write(3, 1'b0, 1, 31, 5, 4, 0);
    cfg_write(4, 1'b1, 0, 0, 0, 0, 1);
    cfg_write(5, 1'b1, 0, 0, 0, 0, 2);
    v = '0; v[3*FW +: FW] = 8'd100; v[4*FW +: FW] = 8'd127; v[1*FW +: FW] = 8'd31;
    run_vec(v, 2, 0, 3, 0, 1'b0);
    v[1*FW +: FW] = 8'd32;
    run_vec(v, 1, 0, 3, 0, 1'b0);

    // Self-loop at the root trips the depth guard.
    cfg_write(0, 1'b0, 0, 0, 0, 0, 0);
    run_vec(v, 0, 1, MD, 0, 1'b0);

    // Reset in the middle of a walk.
    in_valid = 1'b1; in_feat = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("midrst_no_result", saw, 0);
    run_vec(v, 0, 0, 0, 0, 1'b0);

    // Random tables over a small address window so trees connect, random vectors.
    for (int it = 0; it < 60; it++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        cfg_write($urandom_range(0, 7), ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                  $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3));
      end
      for (int f = 0; f < NF; f++) v[f*FW +: FW] = FW'($urandom_range(0, 255));
      model_walk(v, ec, ee, es);
      run_vec(v, ec, ee, es, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
